// File: rtl/addsub_pkg.sv
// Shared types for the add/sub/accumulate pipeline.
package addsub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Opcode carried alongside each operand word
  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_ACC  = 2'd2,
    OP_LOAD = 2'd3
  } op_e;

endpackage

// File: rtl/addsub_core.sv
// Combinational stage-2 function: (op, a, b, acc) -> (rez, ovf, acc_next).
// Define ADDSUB_SAT_EN to make ACC saturate at all-ones instead of wrapping.
module addsub_core
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  localparam int unsigned RW   = WIDTH + 1
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [RW-1:0]    acc,
  output logic [RW-1:0]    rez,
  output logic             ovf,
  output logic [RW-1:0]    acc_next
);

  localparam int unsigned SW = RW + 1;

  logic [RW-1:0] a_ext;
  logic [RW-1:0] b_ext;
  logic [SW-1:0] acc_sum;

  assign a_ext   = RW'(a);
  assign b_ext   = RW'(b);
  assign acc_sum = SW'(acc) + SW'(a);

  // Result, flag and next accumulator per opcode; acc holds unless ACC/LOAD
  always_comb begin
    rez      = '0;
    ovf      = 1'b0;
    acc_next = acc;
    case (op)
      OP_ADD: begin
        rez = a_ext + b_ext;
      end
      OP_SUB: begin
        rez = a_ext - b_ext;
        ovf = (a < b);
      end
      OP_ACC: begin
`ifdef ADDSUB_SAT_EN
        if (acc_sum[RW]) begin
          rez = '1;
          ovf = 1'b1;
        end else begin
          rez = acc_sum[RW-1:0];
        end
`else
        rez = acc_sum[RW-1:0];
        ovf = acc_sum[RW];
`endif
        acc_next = rez;
      end
      OP_LOAD: begin
        rez      = a_ext;
        acc_next = a_ext;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/addsub_acc_pipe.sv
// Two-stage add/sub/accumulate pipeline with valid/ready handshake.
// ADDSUB_SAT_EN (see addsub_core) selects saturating accumulation.
module addsub_acc_pipe
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  localparam int unsigned RW   = WIDTH + 1
) (
  input  logic             Clk_in,
  input  logic             Rst_in,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic [1:0]       Sel_in,
  input  logic             Valid_in,
  output logic             Ready_out,
  output logic [RW-1:0]    Rez_out,
  output logic             Ovf_out,
  output logic             Valid_out,
  input  logic             Ready_in
);

  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  op_e              op1;
  logic             v1;
  logic [RW-1:0]    acc;

  logic             en;
  logic [RW-1:0]    core_rez;
  logic             core_ovf;
  logic [RW-1:0]    core_acc_next;

  // Whole pipeline advances together whenever stage 2 is empty or draining
  assign en        = !Valid_out || Ready_in;
  assign Ready_out = en;

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .op       (op1),
    .a        (a1),
    .b        (b1),
    .acc      (acc),
    .rez      (core_rez),
    .ovf      (core_ovf),
    .acc_next (core_acc_next)
  );

  // Stage 1 and stage 2 registers; acc only moves with a valid ACC/LOAD word
  always_ff @(posedge Clk_in) begin
    if (Rst_in) begin
      a1        <= '0;
      b1        <= '0;
      op1       <= OP_ADD;
      v1        <= 1'b0;
      Rez_out   <= '0;
      Ovf_out   <= 1'b0;
      Valid_out <= 1'b0;
      acc       <= '0;
    end else if (en) begin
      a1        <= A_in;
      b1        <= B_in;
      op1       <= op_e'(Sel_in);
      v1        <= Valid_in;
      Rez_out   <= core_rez;
      Ovf_out   <= core_ovf;
      Valid_out <= v1;
      if (v1 && (op1 == OP_ACC || op1 == OP_LOAD)) begin
        acc <= core_acc_next;
      end
    end
  end

endmodule
